branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit.sv | 115 +++++++++++
 tb/tb_branch_predict_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - 2-bit BHT branch predictor and resolver; BRANCH_PERF_EN enables the perf counters
module branch_predict_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic [XLEN-1:0] res_pc,
    input  logic [2:0]      res_branch,
    input  logic            res_less,
    input  logic            res_zero,
    input  logic            res_pred_taken,
    input  logic            flush,
    output logic            pc_src_a,
    output logic            pc_src_b,
    output logic            redirect_valid,
    output logic            mispredict,
    output logic            actual_taken,
    output logic [31:0]     br_cnt,
    output logic [31:0]     miss_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             taken;
    logic             accepted;
    logic             is_cond;
    logic             src_a;
    logic             src_b;
    logic             unused_pc_bits;

    // Word-aligned PCs: the low two bits and bits above the index do not select a counter
    assign pred_idx       = pred_pc[IDX_W+1:2];
    assign res_idx        = res_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                              res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

    // Prediction reads the stored counter directly, so a same-cycle update is not visible
    assign pred_taken = bht[pred_idx][1];

    // Decode branch type into taken, acceptance and PC adder selects
    always_comb begin
        taken    = 1'b0;
        is_cond  = res_branch[2];
        case (res_branch)
            3'b001:  taken = 1'b1;
            3'b010:  taken = 1'b1;
            3'b100:  taken = res_zero;
            3'b101:  taken = !res_zero;
            3'b110:  taken = res_less;
            3'b111:  taken = !res_less;
            default: taken = 1'b0;
        endcase
        accepted = res_valid && !flush && (res_branch != 3'b000) && (res_branch != 3'b011);
        src_a    = taken;
        src_b    = (res_branch == 3'b010);
    end

    // Register resolution results; idle or killed cycles leave everything low
    always_ff @(posedge clk) begin
        if (rst || !accepted) begin
            redirect_valid <= 1'b0;
            mispredict     <= 1'b0;
            actual_taken   <= 1'b0;
            pc_src_a       <= 1'b0;
            pc_src_b       <= 1'b0;
        end else begin
            redirect_valid <= 1'b1;
            mispredict     <= (taken != res_pred_taken);
            actual_taken   <= taken;
            pc_src_a       <= src_a;
            pc_src_b       <= src_b;
        end
    end

    // Saturating counter update for accepted conditional branches only
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (accepted && is_cond) begin
            if (taken && bht[res_idx] != 2'b11) begin
                bht[res_idx] <= bht[res_idx] + 2'b01;
            end else if (!taken && bht[res_idx] != 2'b00) begin
                bht[res_idx] <= bht[res_idx] - 2'b01;
            end
        end
    end

`ifdef BRANCH_PERF_EN
    // Count accepted branches and their mispredictions, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt   <= 32'd0;
            miss_cnt <= 32'd0;
        end else if (accepted) begin
            br_cnt <= br_cnt + 32'd1;
            if (taken != res_pred_taken) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`else
    assign br_cnt   = 32'd0;
    assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed self-checking bench for branch_predict_unit
module tb_branch_predict_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [2:0]  res_branch;
    logic        res_less;
    logic        res_zero;
    logic        res_pred_taken;
    logic        flush;
    logic        pc_src_a;
    logic        pc_src_b;
    logic        redirect_valid;
    logic        mispredict;
    logic        actual_taken;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    int n_pass;
    int n_total;
    int exp_br;
    int exp_miss;

    branch_predict_unit #(.XLEN(32), .BHT_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_pc(res_pc), .res_branch(res_branch),
        .res_less(res_less), .res_zero(res_zero), .res_pred_taken(res_pred_taken),
        .flush(flush), .pc_src_a(pc_src_a), .pc_src_b(pc_src_b),
        .redirect_valid(redirect_valid), .mispredict(mispredict),
        .actual_taken(actual_taken), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input string tag, input logic [31:0] pc, input logic [2:0] br,
                       input logic zero, input logic less, input logic pt, input logic fl,
                       input logic e_rv, input logic e_at, input logic e_mp, input logic [1:0] e_src);
        res_valid      = 1'b1;
        res_pc         = pc;
        res_branch     = br;
        res_zero       = zero;
        res_less       = less;
        res_pred_taken = pt;
        flush          = fl;
        step();
        check({tag, ".rv"},  {31'd0, redirect_valid}, {31'd0, e_rv});
        check({tag, ".at"},  {31'd0, actual_taken},   {31'd0, e_at});
        check({tag, ".mp"},  {31'd0, mispredict},     {31'd0, e_mp});
        check({tag, ".src"}, {30'd0, pc_src_a, pc_src_b}, {30'd0, e_src});
        if (e_rv) begin
            exp_br++;
            if (e_mp) exp_miss++;
        end
    endtask

    task automatic idle();
        res_valid = 1'b0;
        flush     = 1'b0;
        step();
    endtask

    initial begin
        n_pass = 0; n_total = 0; exp_br = 0; exp_miss = 0;
        rst = 1'b1; pred_pc = 32'h8000_0000;
        res_valid = 1'b1; res_pc = 32'h8000_0010; res_branch = 3'b001;
        res_less = 1'b0; res_zero = 1'b0; res_pred_taken = 1'b0; flush = 1'b0;
        step();
        rst = 1'b0;
        check("rst.rv", {31'd0, redirect_valid}, 32'd0);
        check("rst.mp", {31'd0, mispredict}, 32'd0);
        check("rst.src", {30'd0, pc_src_a, pc_src_b}, 32'd0);
        check("rst.br_cnt", br_cnt, 32'd0);
        check("rst.pred", {31'd0, pred_taken}, 32'd0);
        idle();
        check("idle.rv", {31'd0, redirect_valid}, 32'd0);
        check("idle.src", {30'd0, pc_src_a, pc_src_b}, 32'd0);

        // Train index 4 upward back-to-back, then saturate and walk back down
        pred_pc = 32'h8000_0010;
        check("beq0.pred", {31'd0, pred_taken}, 32'd0);
        req("beq1", 32'h8000_0010, 3'b100, 1, 0, 0, 0, 1, 1, 1, 2'b10);
        check("beq1.pred", {31'd0, pred_taken}, 32'd1);
        req("beq2", 32'h8000_0010, 3'b100, 1, 0, 1, 0, 1, 1, 0, 2'b10);
        req("beq3", 32'h8000_0010, 3'b100, 1, 0, 1, 0, 1, 1, 0, 2'b10);
        req("beq4", 32'h8000_0010, 3'b100, 1, 0, 1, 0, 1, 1, 0, 2'b10);
        req("beqn1", 32'h8000_0010, 3'b100, 0, 0, 1, 0, 1, 0, 1, 2'b00);
        check("sat.pred", {31'd0, pred_taken}, 32'd1);
        req("beqn2", 32'h8000_0010, 3'b100, 0, 0, 1, 0, 1, 0, 1, 2'b00);
        check("down.pred", {31'd0, pred_taken}, 32'd0);

        // Unconditional jumps redirect but leave the counter at 01
        req("jalr", 32'h8000_0010, 3'b010, 0, 0, 0, 0, 1, 1, 1, 2'b11);
        req("jal", 32'h8000_0010, 3'b001, 0, 0, 1, 0, 1, 1, 0, 2'b10);
        check("jmp.pred", {31'd0, pred_taken}, 32'd0);

        // Flushed bge is dropped; the retry updates index 8
        pred_pc = 32'h8000_0020;
        req("bgef", 32'h8000_0020, 3'b111, 0, 0, 0, 1, 0, 0, 0, 2'b00);
        check("bgef.pred", {31'd0, pred_taken}, 32'd0);
        req("bge", 32'h8000_0020, 3'b111, 0, 0, 0, 0, 1, 1, 1, 2'b10);
        check("bge.pred", {31'd0, pred_taken}, 32'd1);

        // Reserved type is ignored; bne taken and blt not-taken at index 12
        pred_pc = 32'h8000_0030;
        req("rsv", 32'h8000_0030, 3'b011, 1, 1, 0, 0, 0, 0, 0, 2'b00);
        check("rsv.pred", {31'd0, pred_taken}, 32'd0);
        req("bne", 32'h8000_0030, 3'b101, 0, 0, 1, 0, 1, 1, 0, 2'b10);
        check("bne.pred", {31'd0, pred_taken}, 32'd1);
        req("bltn", 32'h8000_0030, 3'b110, 0, 0, 1, 0, 1, 0, 1, 2'b00);
        check("bltn.pred", {31'd0, pred_taken}, 32'd0);

        // Same-index read and update: old value this cycle, new value next
        pred_pc = 32'h0000_0040;
        res_valid = 1'b1; res_pc = 32'h0000_0040; res_branch = 3'b110; res_less = 1'b1;
        #1;
        check("byp.pre", {31'd0, pred_taken}, 32'd0);
        req("blt", 32'h0000_0040, 3'b110, 0, 1, 0, 0, 1, 1, 1, 2'b10);
        check("byp.post", {31'd0, pred_taken}, 32'd1);
        idle();
        check("idle2.rv", {31'd0, redirect_valid}, 32'd0);

`ifdef BRANCH_PERF_EN
        check("br_cnt", br_cnt, exp_br);
        check("miss_cnt", miss_cnt, exp_miss);
`else
        check("br_cnt0", br_cnt, 32'd0);
        check("miss_cnt0", miss_cnt, 32'd0);
`endif

        // Reset restores every counter to weakly not-taken
        pred_pc = 32'h8000_0020;
        check("pre_rst.pred", {31'd0, pred_taken}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2.pred", {31'd0, pred_taken}, 32'd0);
        check("rst2.cnt", br_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
